// File: rtl/pid_scheduler.sv
// -----------------------------------------------------------------------------
// pid_scheduler
//
// Purpose:
//   Time-multiplexes one shared PID arithmetic core across NUM_CHN motor
//   channels. Setpoints and stop flags come from the UART command decoder.
//   On every sample tick the scheduler walks channels 0..NUM_CHN-1. For each
//   channel it forms a target, hands target and measurement to the PID core,
//   waits for the result, clamps it and stores it in that channel's duty
//   register for the PWM stage.
//
// Build option:
//   PID_SCHED_RAMP_EN  defined   : target slews toward the setpoint by at most
//                                  RAMP_STEP per tick.
//                      undefined : target = setpoint at each LOAD.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   tr_valid_i      setpoint write strobe (tr_chn_i >= NUM_CHN is ignored)
//   tr_chn_i        setpoint channel index
//   tr_data_i       signed setpoint
//   stop_i          per-channel stop, 1 = stopped (sampled at that channel's LOAD)
//   meas_i          packed signed measurements, chn k at [k*DATA_WIDTH +: DATA_WIDTH]
//   pid_req_o       request to the PID core
//   pid_chn_o       channel being computed (also qualifies pid_clr_o)
//   pid_target_o    target handed to the PID core
//   pid_meas_o      measurement handed to the PID core
//   pid_clr_o       one-cycle integrator clear for pid_chn_o
//   pid_ack_i       PID result valid
//   pid_out_i       signed PID result
//   duty_o          packed signed duty per channel
//   duty_valid_o    one-cycle pulse per channel when its duty is written
//   busy_o          scheduler is walking the channels
//   overrun_o       sticky: a tick arrived while busy (tick dropped)
//   timeout_o       sticky per-channel PID ack timeout
// -----------------------------------------------------------------------------
module pid_scheduler #(
    parameter int NUM_CHN     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int SAMPLE_DIV  = 50000,
    parameter int RAMP_STEP   = 64,
    parameter int DUTY_MAX    = 1000,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tr_valid_i,
    input  logic [2:0]                    tr_chn_i,
    input  logic [DATA_WIDTH-1:0]         tr_data_i,
    input  logic [NUM_CHN-1:0]            stop_i,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] meas_i,
    output logic                          pid_req_o,
    output logic [2:0]                    pid_chn_o,
    output logic [DATA_WIDTH-1:0]         pid_target_o,
    output logic [DATA_WIDTH-1:0]         pid_meas_o,
    output logic                          pid_clr_o,
    input  logic                          pid_ack_i,
    input  logic [DATA_WIDTH-1:0]         pid_out_i,
    output logic [NUM_CHN*DATA_WIDTH-1:0] duty_o,
    output logic [NUM_CHN-1:0]            duty_valid_o,
    output logic                          busy_o,
    output logic                          overrun_o,
    output logic [NUM_CHN-1:0]            timeout_o
);

    localparam int IDX_W = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    // The REQ wait counter only needs to reach ACK_TIMEOUT-1.
    localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic signed [DATA_WIDTH:0] DMAX_POS = (DATA_WIDTH+1)'(DUTY_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_REQ   = 2'd2,
        S_STORE = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                        r_state;
    logic [IDX_W-1:0]              r_idx;
    logic [CNT_W-1:0]              r_cnt;
    logic [TO_W-1:0]               r_to_cnt;
    logic signed [DATA_WIDTH-1:0]  r_sp   [NUM_CHN];
    logic signed [DATA_WIDTH-1:0]  r_tgt  [NUM_CHN];
    logic signed [DATA_WIDTH-1:0]  r_duty [NUM_CHN];
    logic signed [DATA_WIDTH-1:0]  r_pid_out;
    logic                          r_pid_req;
    logic                          r_pid_clr;
    logic [2:0]                    r_pid_chn;
    logic [DATA_WIDTH-1:0]         r_pid_target;
    logic [DATA_WIDTH-1:0]         r_pid_meas;
    logic [NUM_CHN-1:0]            r_duty_valid;
    logic [NUM_CHN-1:0]            r_timeout;
    logic                          r_overrun;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                          w_tick;
    logic                          w_last;
    logic                          w_wr_ok;
    logic [IDX_W-1:0]              w_wr_idx;
    logic signed [DATA_WIDTH-1:0]  w_sp_cur;
    logic signed [DATA_WIDTH-1:0]  w_tgt_cur;
    logic signed [DATA_WIDTH-1:0]  w_tgt_next;
    logic [DATA_WIDTH-1:0]         w_meas_cur;
    logic signed [DATA_WIDTH:0]    w_out_ext;
    logic signed [DATA_WIDTH-1:0]  w_clamped;

    assign w_tick     = (r_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign w_last     = (r_idx == IDX_W'(NUM_CHN - 1));
    assign w_wr_ok    = tr_valid_i && (int'(tr_chn_i) < NUM_CHN);
    assign w_wr_idx   = tr_chn_i[IDX_W-1:0];
    assign w_sp_cur   = r_sp[r_idx];
    assign w_tgt_cur  = r_tgt[r_idx];
    assign w_meas_cur = meas_i[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];

`ifdef PID_SCHED_RAMP_EN
    localparam logic signed [DATA_WIDTH:0] RAMP_POS = (DATA_WIDTH+1)'(RAMP_STEP);

    // One extra bit on the difference so sp - tgt never wraps; when a step
    // is taken, tgt +/- RAMP_STEP stays strictly between tgt and sp, so the
    // DATA_WIDTH-bit sum cannot overflow either.
    logic signed [DATA_WIDTH:0] w_diff;

    always_comb begin
        w_diff = {w_sp_cur[DATA_WIDTH-1], w_sp_cur} - {w_tgt_cur[DATA_WIDTH-1], w_tgt_cur};
        if (w_diff > RAMP_POS) begin
            w_tgt_next = w_tgt_cur + DATA_WIDTH'(RAMP_STEP);
        end else if (w_diff < -RAMP_POS) begin
            w_tgt_next = w_tgt_cur - DATA_WIDTH'(RAMP_STEP);
        end else begin
            w_tgt_next = w_sp_cur;
        end
    end
`else
    assign w_tgt_next = w_sp_cur;
`endif

    // Clamp on the sign-extended result so the comparison against
    // +/-DUTY_MAX is exact for every DATA_WIDTH-bit input.
    always_comb begin
        w_out_ext = {r_pid_out[DATA_WIDTH-1], r_pid_out};
        if (w_out_ext > DMAX_POS) begin
            w_clamped = DATA_WIDTH'(DUTY_MAX);
        end else if (w_out_ext < -DMAX_POS) begin
            w_clamped = DATA_WIDTH'(-DUTY_MAX);
        end else begin
            w_clamped = r_pid_out;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer
    //
    // PID handshake: pid_req_o rises on entry to REQ and stays high, with
    // pid_chn_o / pid_target_o / pid_meas_o frozen, until the first cycle
    // in which pid_ack_i is sampled high. pid_out_i is captured in that
    // cycle and pid_req_o is low in the next one. pid_ack_i is ignored
    // whenever pid_req_o is low. If no ack arrives within ACK_TIMEOUT
    // request cycles, the channel is abandoned with duty 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_to_cnt     <= '0;
            r_pid_out    <= '0;
            r_pid_req    <= 1'b0;
            r_pid_clr    <= 1'b0;
            r_pid_chn    <= '0;
            r_pid_target <= '0;
            r_pid_meas   <= '0;
            r_duty_valid <= '0;
            r_timeout    <= '0;
            r_overrun    <= 1'b0;
            for (int k = 0; k < NUM_CHN; k++) begin
                r_sp[k]   <= '0;
                r_tgt[k]  <= '0;
                r_duty[k] <= '0;
            end
        end else begin
            r_pid_clr    <= 1'b0;
            r_duty_valid <= '0;

            if (w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_wr_ok) begin
                r_sp[w_wr_idx] <= tr_data_i;
            end

            // A tick that finds the sequencer busy is dropped, not queued.
            if (w_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_idx   <= '0;
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_pid_chn <= 3'(r_idx);
                    if (stop_i[r_idx]) begin
                        r_tgt[r_idx]        <= '0;
                        r_duty[r_idx]       <= '0;
                        r_pid_clr           <= 1'b1;
                        r_duty_valid[r_idx] <= 1'b1;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_tgt[r_idx] <= w_tgt_next;
                        r_pid_target <= w_tgt_next;
                        r_pid_meas   <= w_meas_cur;
                        r_pid_req    <= 1'b1;
                        r_to_cnt     <= '0;
                        r_state      <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (pid_ack_i) begin
                        r_pid_out <= pid_out_i;
                        r_pid_req <= 1'b0;
                        r_state   <= S_STORE;
                    end else if (r_to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                        r_pid_req           <= 1'b0;
                        r_timeout[r_idx]    <= 1'b1;
                        r_duty[r_idx]       <= '0;
                        r_duty_valid[r_idx] <= 1'b1;
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                S_STORE: begin
                    r_duty[r_idx]       <= w_clamped;
                    r_duty_valid[r_idx] <= 1'b1;
                    if (w_last) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_LOAD;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        duty_o = '0;
        for (int k = 0; k < NUM_CHN; k++) begin
            duty_o[k*DATA_WIDTH +: DATA_WIDTH] = r_duty[k];
        end
    end

    assign pid_req_o    = r_pid_req;
    assign pid_chn_o    = r_pid_chn;
    assign pid_target_o = r_pid_target;
    assign pid_meas_o   = r_pid_meas;
    assign pid_clr_o    = r_pid_clr;
    assign duty_valid_o = r_duty_valid;
    assign busy_o       = (r_state != S_IDLE);
    assign overrun_o    = r_overrun;
    assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_pid_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pid_scheduler
//
// Directed bench for pid_scheduler (4 channels, 16-bit data, 400-cycle sample
// period, ack timeout 255). A reference model predicts every observable event
// of a scheduling pass (PID request with target, integrator clear, duty
// write) and pushes it to exp_q before the pass starts; a monitor pops and
// compares as the DUT produces them. A responder process plays the PID core.
// -----------------------------------------------------------------------------
module tb_pid_scheduler;

    localparam int NCH  = 4;
    localparam int DW   = 16;
    localparam int SDIV = 400;
    localparam int RSTP = 64;
    localparam int DMAX = 1000;
    localparam int ATO  = 255;
    localparam int EW   = 21;   // event: {kind[1:0], chn[2:0], value[15:0]}

    // -------------------------------------------------------------------------
    // DUT signals
    // -------------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              rst;
    logic              tr_valid_i;
    logic [2:0]        tr_chn_i;
    logic [DW-1:0]     tr_data_i;
    logic [NCH-1:0]    stop_i;
    logic [NCH*DW-1:0] meas_i;
    logic              pid_req_o;
    logic [2:0]        pid_chn_o;
    logic [DW-1:0]     pid_target_o;
    logic [DW-1:0]     pid_meas_o;
    logic              pid_clr_o;
    logic              pid_ack_i;
    logic [DW-1:0]     pid_out_i;
    logic [NCH*DW-1:0] duty_o;
    logic [NCH-1:0]    duty_valid_o;
    logic              busy_o;
    logic              overrun_o;
    logic [NCH-1:0]    timeout_o;

    pid_scheduler #(
        .NUM_CHN     (NCH),
        .DATA_WIDTH  (DW),
        .SAMPLE_DIV  (SDIV),
        .RAMP_STEP   (RSTP),
        .DUTY_MAX    (DMAX),
        .ACK_TIMEOUT (ATO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tr_valid_i   (tr_valid_i),
        .tr_chn_i     (tr_chn_i),
        .tr_data_i    (tr_data_i),
        .stop_i       (stop_i),
        .meas_i       (meas_i),
        .pid_req_o    (pid_req_o),
        .pid_chn_o    (pid_chn_o),
        .pid_target_o (pid_target_o),
        .pid_meas_o   (pid_meas_o),
        .pid_clr_o    (pid_clr_o),
        .pid_ack_i    (pid_ack_i),
        .pid_out_i    (pid_out_i),
        .duty_o       (duty_o),
        .duty_valid_o (duty_valid_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o),
        .timeout_o    (timeout_o)
    );

    // -------------------------------------------------------------------------
    // Clock
    // -------------------------------------------------------------------------
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Bench state
    // -------------------------------------------------------------------------
    int          vectors     = 0;
    int          miscompares = 0;
    logic [EW-1:0] exp_q[$];

    int          m_sp   [NCH];
    int          m_tgt  [NCH];
    int          m_duty [NCH];
    int          m_meas [NCH] = '{7, 107, -207, -5};
    logic [NCH-1:0] m_to;
    logic        m_ovr;

    int          rsp_delay [NCH];
    int          rsp_out   [NCH];
    bit          rsp_noack [NCH];
    int          noack_cycles = 0;
    int          spur_req  = 0;
    int          spur_done = 0;
    bit          mon_en    = 1'b1;

    // -------------------------------------------------------------------------
    // Reference helpers
    // -------------------------------------------------------------------------
    function automatic int ramp(input int sp, input int tgt);
`ifdef PID_SCHED_RAMP_EN
        int d;
        d = sp - tgt;
        if (d > RSTP)       return tgt + RSTP;
        else if (d < -RSTP) return tgt - RSTP;
        else                return sp;
`else
        return sp + 0 * tgt;
`endif
    endfunction

    function automatic int clampv(input int v);
        if (v > DMAX)       return DMAX;
        else if (v < -DMAX) return -DMAX;
        else                return v;
    endfunction

    function automatic logic [EW-1:0] mk_ev(input int kind, input int chn, input int val);
        return {kind[1:0], chn[2:0], val[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard: pop one expected event per observed event
    // -------------------------------------------------------------------------
    task automatic got(input logic [EW-1:0] ev);
        logic [EW-1:0] e;
        vectors++;
        assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL spurious_event observed=%0h expected=none", ev);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("event", {11'b0, ev}, {11'b0, e});
        end
    endtask

    // Predict one full pass using current setpoints, stops and PID behaviour.
    task automatic push_cycle();
        for (int k = 0; k < NCH; k++) begin
            if (stop_i[k]) begin
                m_tgt[k]  = 0;
                m_duty[k] = 0;
                exp_q.push_back(mk_ev(2, k, 0));
                exp_q.push_back(mk_ev(1, k, 0));
            end else begin
                m_tgt[k] = ramp(m_sp[k], m_tgt[k]);
                exp_q.push_back(mk_ev(0, k, m_tgt[k]));
                if (rsp_noack[k]) begin
                    m_duty[k] = 0;
                    m_to[k]   = 1'b1;
                end else begin
                    m_duty[k] = clampv(rsp_out[k]);
                end
                exp_q.push_back(mk_ev(1, k, m_duty[k]));
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor (samples on the falling edge)
    // -------------------------------------------------------------------------
    initial begin
        bit prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                prev_req = pid_req_o;
            end else begin
                if (pid_req_o && !prev_req) begin
                    got(mk_ev(0, int'(pid_chn_o), int'(pid_target_o)));
                    check("req_meas", {16'b0, pid_meas_o}, {16'b0, m_meas[pid_chn_o][15:0]});
                end
                if (pid_clr_o) begin
                    got(mk_ev(2, int'(pid_chn_o), 0));
                end
                for (int k = 0; k < NCH; k++) begin
                    if (duty_valid_o[k]) begin
                        got(mk_ev(1, k, int'(duty_o[k*DW +: DW])));
                    end
                end
                prev_req = pid_req_o;
            end
        end
    end

    // -------------------------------------------------------------------------
    // PID core responder
    // -------------------------------------------------------------------------
    initial begin
        int c;
        int n;
        pid_ack_i = 1'b0;
        pid_out_i = '0;
        forever begin
            @(posedge clk); #1;
            if ((spur_req != spur_done) && !pid_req_o && !busy_o) begin
                // Ack with no request outstanding: must leave duties untouched.
                pid_ack_i = 1'b1;
                pid_out_i = 16'd999;
                spur_done++;
                @(posedge clk); #1;
                pid_ack_i = 1'b0;
            end else if (pid_req_o && !rst) begin
                c = int'(pid_chn_o);
                if (rsp_noack[c]) begin
                    n = 0;
                    while (pid_req_o && n < 2000) begin
                        n++;
                        @(posedge clk); #1;
                    end
                    noack_cycles = n;
                end else begin
                    for (int i = 1; i < rsp_delay[c]; i++) begin
                        @(posedge clk); #1;
                    end
                    pid_ack_i = 1'b1;
                    pid_out_i = rsp_out[c][15:0];
                    @(posedge clk); #1;
                    pid_ack_i = 1'b0;
                    @(posedge clk); #1;
                    if (mon_en) check("ack_to_duty_valid", {31'b0, duty_valid_o[c]}, 32'd1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic write_sp(input int chn, input int data);
        tr_valid_i = 1'b1;
        tr_chn_i   = chn[2:0];
        tr_data_i  = data[15:0];
        @(posedge clk); #1;
        tr_valid_i = 1'b0;
        if (chn < NCH) m_sp[chn] = data;
    endtask

    // Run one scheduling pass; optionally write a setpoint during chn0 REQ.
    task automatic run_cycle(input int late_chn, input int late_data);
        int n;
        bit found;
        if (late_chn >= 0) m_sp[late_chn] = late_data;
        push_cycle();
        n = 0;
        while (!busy_o && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_start", {31'b0, busy_o}, 32'd1);
        @(posedge clk); #1;
        if (!stop_i[0]) check("tick_to_req", {31'b0, pid_req_o}, 32'd1);
        if (late_chn >= 0) begin
            found = 1'b0;
            n = 0;
            while (!found && n < 50) begin
                if (pid_req_o && pid_chn_o == 3'd0) found = 1'b1;
                else begin
                    @(posedge clk); #1;
                    n++;
                end
            end
            check("late_wr_window", {31'b0, found}, 32'd1);
            tr_valid_i = 1'b1;
            tr_chn_i   = late_chn[2:0];
            tr_data_i  = late_data[15:0];
            @(posedge clk); #1;
            tr_valid_i = 1'b0;
        end
        n = 0;
        while (busy_o && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_end", {31'b0, busy_o}, 32'd0);
        @(negedge clk); #1;
        check("queue_drained", exp_q.size(), 32'd0);
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("duty_o[%0d]", k), {16'b0, duty_o[k*DW +: DW]}, {16'b0, m_duty[k][15:0]});
        end
        check("timeout_o", {28'b0, timeout_o}, {28'b0, m_to});
        check("overrun_o", {31'b0, overrun_o}, {31'b0, m_ovr});
        @(posedge clk); #1;
    endtask

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL watchdog observed=running expected=finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "simulation time limit reached");
    end

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        int n;
        rst        = 1'b1;
        tr_valid_i = 1'b0;
        tr_chn_i   = '0;
        tr_data_i  = '0;
        stop_i     = '0;
        for (int k = 0; k < NCH; k++) begin
            meas_i[k*DW +: DW] = m_meas[k][15:0];
            m_sp[k]      = 0;
            m_tgt[k]     = 0;
            m_duty[k]    = 0;
            rsp_delay[k] = 3;
            rsp_noack[k] = 1'b0;
        end
        m_to  = '0;
        m_ovr = 1'b0;
        rsp_out = '{500, 10, 20, 30};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pid_req",    {31'b0, pid_req_o},    32'd0);
        check("rst_pid_chn",    {29'b0, pid_chn_o},    32'd0);
        check("rst_pid_target", {16'b0, pid_target_o}, 32'd0);
        check("rst_pid_meas",   {16'b0, pid_meas_o},   32'd0);
        check("rst_pid_clr",    {31'b0, pid_clr_o},    32'd0);
        check("rst_duty_lo",    duty_o[31:0],          32'd0);
        check("rst_duty_hi",    duty_o[63:32],         32'd0);
        check("rst_duty_valid", {28'b0, duty_valid_o}, 32'd0);
        check("rst_busy",       {31'b0, busy_o},       32'd0);
        check("rst_overrun",    {31'b0, overrun_o},    32'd0);
        check("rst_timeout",    {28'b0, timeout_o},    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Ramp up channel 0 toward 200 over four ticks
        write_sp(0, 200);
        repeat (4) run_cycle(-1, 0);

        // Out-of-range channel write and an unsolicited ack are both ignored
        write_sp(5, 777);
        spur_req++;
        n = 0;
        while (spur_done != spur_req && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("spur_ack_sent", spur_done, spur_req);
        run_cycle(-1, 0);

        // Clamp: large negative, exact positive limit
        rsp_out = '{500, 300, -3000, 1000};
        write_sp(1, 150);
        write_sp(3, -100);
        run_cycle(-1, 0);

        // Stop channel 1 (duty was 300); clamp exact negative and +/- overshoot
        rsp_out = '{-1000, 300, 1001, -1001};
        stop_i  = 4'b0010;
        run_cycle(-1, 0);
        stop_i  = 4'b0000;

        // Setpoint written to chn2 while chn0 is in REQ is used in the same pass
        rsp_out = '{40, -50, 60, -70};
        run_cycle(2, -500);

        // Timeout on channel 3, then a retry on the next tick
        rsp_noack[3] = 1'b1;
        run_cycle(-1, 0);
        check("ack_timeout_len", noack_cycles, ATO);
        rsp_noack[3] = 1'b0;
        rsp_out = '{11, 22, 33, 44};
        run_cycle(-1, 0);

        // Overrun: slow PID acks stretch the pass past the next tick
        for (int k = 0; k < NCH; k++) rsp_delay[k] = 150;
        rsp_out = '{-123, 456, -789, 999};
        m_ovr = 1'b1;
        run_cycle(-1, 0);
        for (int k = 0; k < NCH; k++) rsp_delay[k] = 3;
        rsp_out = '{5, 6, 7, 8};
        run_cycle(-1, 0);

        // Reset mid-pass aborts at once
        mon_en = 1'b0;
        n = 0;
        while (!pid_req_o && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrst_req_seen", {31'b0, pid_req_o}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_pid_req",  {31'b0, pid_req_o}, 32'd0);
        check("midrst_busy",     {31'b0, busy_o},    32'd0);
        check("midrst_duty_lo",  duty_o[31:0],       32'd0);
        check("midrst_duty_hi",  duty_o[63:32],      32'd0);
        check("midrst_overrun",  {31'b0, overrun_o}, 32'd0);
        check("midrst_timeout",  {28'b0, timeout_o}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        repeat (8) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
